// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared types and constants for the execute-to-writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int c_xlen = 32;
  localparam int c_regw = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    DRAIN     = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic              we;
    logic [c_regw-1:0] rd;
    logic [c_xlen-1:0] data;
  } wb_lane_t;

  // Writes to x0 collapse to a full bubble so forwarding on x0 always sees 0.
  function automatic wb_lane_t make_lane(input logic              valid,
                                         input logic [c_regw-1:0] rd,
                                         input logic [c_xlen-1:0] data);
    wb_lane_t lane;
    lane = '0;
    if (valid && (rd != '0)) begin
      lane.we   = 1'b1;
      lane.rd   = rd;
      lane.data = data;
    end
    return lane;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Combinational byte/half extraction and sign/zero extension of
//            returned load data.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      F3_LW:   o_data = i_rdata;
      default: o_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ex_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_wb_stage
// Brief    : Execute-to-writeback register stage for IXU1/IXU2/LSU lanes with
//            outstanding-load tracking. Optional macro WB_LOAD_TIMEOUT_EN adds
//            a load watchdog and the load_timeout_err output.
// Revision : 1.0 - initial release
// ============================================================================
module ex_wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
`ifdef WB_LOAD_TIMEOUT_EN
  ,
  parameter int LOAD_TIMEOUT = 64
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ixu1_ex_valid,
  input  logic [REGW-1:0] ixu1_ex_rd,
  input  logic [XLEN-1:0] ixu1_ex_result,
  input  logic            ixu2_ex_valid,
  input  logic [REGW-1:0] ixu2_ex_rd,
  input  logic [XLEN-1:0] ixu2_ex_result,
  input  logic            lsu_ex_valid,
  input  logic [REGW-1:0] lsu_ex_rd,
  input  logic            lsu_ex_is_load,
  input  logic            lsu_ex_is_store,
  input  logic [2:0]      lsu_ex_funct3,
  input  logic [XLEN-1:0] lsu_ex_result,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            ixu1_wb_we,
  output logic [REGW-1:0] ixu1_wb_rd,
  output logic [XLEN-1:0] ixu1_wb_data,
  output logic            ixu2_wb_we,
  output logic [REGW-1:0] ixu2_wb_rd,
  output logic [XLEN-1:0] ixu2_wb_data,
  output logic            lsu_wb_we,
  output logic [REGW-1:0] lsu_wb_rd,
  output logic [XLEN-1:0] lsu_wb_data,
  output logic            lsu_wb_is_load,
  output logic            wb_stall
`ifdef WB_LOAD_TIMEOUT_EN
  ,
  output logic            load_timeout_err
`endif
);

  wb_state_e       r_state;
  wb_state_e       w_state_nxt;
  wb_lane_t        r_ixu1, r_ixu2, r_lsu;
  wb_lane_t        w_ixu1_nxt, w_ixu2_nxt, w_lsu_nxt;
  logic            r_lsu_is_load, w_lsu_is_load_nxt;
  logic [REGW-1:0] r_ld_rd;
  logic [2:0]      r_ld_funct3;
  logic [1:0]      r_ld_off;
  logic [XLEN-1:0] w_ld_data;
  logic            w_load_accept;
  logic            w_timeout;

  assign w_load_accept = (r_state == IDLE) && lsu_ex_valid && lsu_ex_is_load && !flush;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .i_funct3(r_ld_funct3),
    .i_offset(r_ld_off),
    .i_rdata (dmem_rdata),
    .o_data  (w_ld_data)
  );

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(LOAD_TIMEOUT + 1);

  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_timeout_err;

  // Counts cycles spent waiting (including DRAIN); the final waiting cycle
  // without data is the one that fires.
  assign w_timeout = (r_state != IDLE) && !dmem_rvalid &&
                     (r_wait_cnt == c_cnt_w'(LOAD_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_load_accept) begin
        r_wait_cnt <= '0;
      end else if (r_state != IDLE) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign load_timeout_err = r_timeout_err;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_load_accept) w_state_nxt = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if (dmem_rvalid || w_timeout) w_state_nxt = IDLE;
        else if (flush)               w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (dmem_rvalid || w_timeout) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ixu1_nxt        = '0;
    w_ixu2_nxt        = '0;
    w_lsu_nxt         = '0;
    w_lsu_is_load_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (!flush) begin
          w_ixu1_nxt = make_lane(ixu1_ex_valid, ixu1_ex_rd, ixu1_ex_result);
          w_ixu2_nxt = make_lane(ixu2_ex_valid, ixu2_ex_rd, ixu2_ex_result);
          w_lsu_nxt  = make_lane(lsu_ex_valid && !lsu_ex_is_load && !lsu_ex_is_store,
                                 lsu_ex_rd, lsu_ex_result);
        end
      end
      LOAD_WAIT: begin
        // Data arriving together with a flush belongs to a squashed load.
        if (dmem_rvalid && !flush) begin
          w_lsu_nxt         = make_lane(1'b1, r_ld_rd, w_ld_data);
          w_lsu_is_load_nxt = w_lsu_nxt.we;
        end
      end
      default: ;
    endcase
  end

  assign wb_stall = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_rd       <= '0;
      r_ld_funct3   <= '0;
      r_ld_off      <= '0;
      r_ixu1        <= '0;
      r_ixu2        <= '0;
      r_lsu         <= '0;
      r_lsu_is_load <= 1'b0;
    end else begin
      if (w_load_accept) begin
        r_ld_rd     <= lsu_ex_rd;
        r_ld_funct3 <= lsu_ex_funct3;
        r_ld_off    <= lsu_ex_result[1:0];
      end
      r_ixu1        <= w_ixu1_nxt;
      r_ixu2        <= w_ixu2_nxt;
      r_lsu         <= w_lsu_nxt;
      r_lsu_is_load <= w_lsu_is_load_nxt;
    end
  end

  assign ixu1_wb_we     = r_ixu1.we;
  assign ixu1_wb_rd     = r_ixu1.rd;
  assign ixu1_wb_data   = r_ixu1.data;
  assign ixu2_wb_we     = r_ixu2.we;
  assign ixu2_wb_rd     = r_ixu2.rd;
  assign ixu2_wb_data   = r_ixu2.data;
  assign lsu_wb_we      = r_lsu.we;
  assign lsu_wb_rd      = r_lsu.rd;
  assign lsu_wb_data    = r_lsu.data;
  assign lsu_wb_is_load = r_lsu_is_load;

endmodule
`default_nettype wire

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute-to-writeback pipeline stage for the VLIW core.
- Registers the results of the IXU1, IXU2 and LSU lanes at the end of execute and drives the writeback buses. Those buses feed both the register file and the execute-stage operand forwarding logic.
- Owns outstanding loads: stalls the bundle path while a load is in flight, then aligns and sign-extends the returned data.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register index width.
- LOAD_TIMEOUT, 64, cycles in LOAD_WAIT before error (used only with WB_LOAD_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  squash the bundle in execute and any load in flight.
- ixu1_ex_valid  in  1  IXU1 result valid.
- ixu1_ex_rd  in  REGW  IXU1 destination.
- ixu1_ex_result  in  XLEN  IXU1 result.
- ixu2_ex_valid / ixu2_ex_rd / ixu2_ex_result  in  1/REGW/XLEN  same for IXU2.
- lsu_ex_valid  in  1  LSU op valid.
- lsu_ex_rd  in  REGW  LSU destination.
- lsu_ex_is_load  in  1  op is a load.
- lsu_ex_is_store  in  1  op is a store.
- lsu_ex_funct3  in  3  RV32 load size/sign (LB, LH, LW, LBU, LHU).
- lsu_ex_result  in  XLEN  non-load result, or effective address for a load.
- dmem_rvalid  in  1  load data return strobe.
- dmem_rdata  in  XLEN  raw memory word.
- ixu1_wb_we / ixu1_wb_rd / ixu1_wb_data  out  1/REGW/XLEN  IXU1 writeback.
- ixu2_wb_we / ixu2_wb_rd / ixu2_wb_data  out  1/REGW/XLEN  IXU2 writeback.
- lsu_wb_we / lsu_wb_rd / lsu_wb_data  out  1/REGW/XLEN  LSU writeback.
- lsu_wb_is_load  out  1  LSU writeback carries load data.
- wb_stall  out  1  freeze issue/execute; combinational from state only.
- load_timeout_err  out  1  sticky error (present only with WB_LOAD_TIMEOUT_EN).

Behaviour:
- Reset: all outputs 0; state IDLE; load_timeout_err 0.
- Bubble encoding:
  - Any non-writing lane drives we=0, rd=0, data=0.
  - Any lane with rd=0 drives we=0 and data=0, even if valid.
  - This guarantees forwarding matches on x0 deliver 0.
- States:
  - IDLE: lanes registered every cycle, 1-cycle latency EX->WB. Stores and invalid lanes become bubbles. LSU non-load ops write rd with result, lsu_wb_is_load=0.
  - IDLE -> LOAD_WAIT: on lsu_ex_valid & lsu_ex_is_load & !flush.
    - Captures rd, funct3 and addr[1:0].
    - IXU lanes of that bundle register normally; the LSU lane is a bubble that cycle.
  - LOAD_WAIT:
    - wb_stall=1; IXU lanes driven as bubbles; EX inputs ignored.
    - On dmem_rvalid, the next edge presents lsu_wb_we=1, lsu_wb_rd=captured rd, lsu_wb_data=aligned data, lsu_wb_is_load=1, for exactly one cycle; state returns to IDLE.
    - Minimum load latency: rvalid one cycle after acceptance.
    - dmem_rvalid sampled in IDLE is ignored.
  - LOAD_WAIT -> DRAIN: on flush without rvalid in the same cycle.
    - If flush and rvalid coincide, the data is discarded and state returns to IDLE.
  - DRAIN: wb_stall=1; all lanes bubbled; the next rvalid is discarded and state returns to IDLE.
- Flush in IDLE: the next WB cycle is an all-bubble bundle; no load captured.
- Alignment (funct3):
  - LB/LBU select byte addr[1:0].
  - LH/LHU select half addr[1].
  - Sign- or zero-extend to XLEN; LW passes through.
  - Undefined funct3 treated as LW.
- Reset mid-load: state IDLE immediately; a later rvalid is ignored.

Optional Feature:
- Macro: WB_LOAD_TIMEOUT_EN.
- Defined:
  - Counter runs in LOAD_WAIT/DRAIN.
  - When it reaches LOAD_TIMEOUT without rvalid, load_timeout_err sets (sticky until rst), the load is dropped and state returns to IDLE.
- Undefined: no counter, no load_timeout_err port; the FSM waits indefinitely.

Decomposition:
- Package wb_pkg:
  - wb_state_e (IDLE, LOAD_WAIT, DRAIN).
  - Funct3 load constants (F3_LB=3'b000, F3_LH=3'b001, F3_LW=3'b010, F3_LBU=3'b100, F3_LHU=3'b101).
  - Lane struct {we, rd, data}.
- Sub-module load_align: purely combinational funct3/offset extractor and extender.

Test Plan:
- IXU1 valid rd=5 result=0x11, IXU2 rd=0 result=0xFF -> next cycle ixu1_wb_we=1 rd=5 data=0x11; ixu2_wb_we=0 rd=0 data=0.
- LB at addr[1:0]=2'b11, rvalid 3 cycles later with rdata=0x80FF_1234, rd=7 -> wb_stall high for 3 cycles, then lsu_wb_we=1 rd=7 data=0xFFFF_FF80 is_load=1 for one cycle.
- LHU addr[1]=1, rdata=0x9ABC_0000 -> lsu_wb_data=0x0000_9ABC.
- Flush in cycle 2 of LOAD_WAIT, rvalid in cycle 4 -> state goes to DRAIN, lsu_wb_we stays 0, wb_stall drops after rvalid.
- rst asserted during LOAD_WAIT, then rvalid -> all outputs 0 immediately, no writeback afterwards.
- With WB_LOAD_TIMEOUT_EN, LOAD_TIMEOUT=8, no rvalid -> load_timeout_err=1 after 8 cycles, wb_stall=0, error held until rst.
